cfu_issue: RTL and testbench
============================

// Module: cfu_issue
// PURPOSE
//  CPU-side initiator for the CFU port; it drives the cfu block's valid/ctrl/src inputs and consumes its stall/result.
//  Accepts one custom-instruction request from the execute stage (valid/ready), registers the operands and issues them to the CFU.
//  Holds the request stable while the CFU stalls, captures the result and returns it to writeback (valid/ready).
//  A watchdog aborts a CFU that stalls too long; a busy-cycle counter supports benchmarking.
// PARAMETERS
//  TIMEOUT  256  max consecutive CFU-stall cycles per op before abort; 0 disables the watchdog
//  CNT_W    32   width of the busy-cycle counter
// PORTS
//  clk_i         in   1                 clock
//  rst_i         in   1                 synchronous reset, active-high
//  stall_i       in   1                 global pipeline stall; freezes this block
//  req_valid_i   in   1                 execute stage presents a CFU op
//  req_ready_o   out  1                 block accepts the op this cycle
//  req_ctrl_i    in   `CFU_CTRL_WIDTH   funct bits for the op
//  req_src1_i    in   `XLEN             rs1 value
//  req_src2_i    in   `XLEN             rs2 value
//  rsp_valid_o   out  1                 result available
//  rsp_ready_i   in   1                 writeback takes the result
//  rsp_rslt_o    out  `XLEN             result
//  rsp_err_o     out  1                 result came from a watchdog abort (rslt = 0)
//  cfu_valid_o   out  1                 to cfu valid_i
//  cfu_ctrl_o    out  `CFU_CTRL_WIDTH   to cfu cfu_ctrl_i
//  cfu_src1_o    out  `XLEN             to cfu src1_i
//  cfu_src2_o    out  `XLEN             to cfu src2_i
//  cfu_stall_o   out  1                 to cfu stall_i; equals stall_i
//  cfu_stall_i   in   1                 from cfu stall_o; 1 = result not ready
//  cfu_rslt_i    in   `XLEN             from cfu rslt_o; valid when cfu_valid_o & !cfu_stall_i
//  busy_cnt_o    out  CNT_W             cycles spent outside IDLE, saturating
// BEHAVIOUR
//  CFU protocol:
//   - ctrl/src are held constant while cfu_valid_o=1.
//   - The result is taken in the cycle where cfu_valid_o=1 and cfu_stall_i=0.
//   - cfu_valid_o is 1 for exactly one such completion per op.
//  FSM states and transitions:
//   - IDLE: req_ready_o = !stall_i. On req_valid_i & req_ready_o: latch ctrl/src1/src2 into op regs, clear wdog, go WAIT.
//   - WAIT: cfu_valid_o = 1, driving the op regs.
//     - cfu_stall_i=0: rslt_q <= cfu_rslt_i, err_q <= 0, go DONE.
//     - Otherwise wdog++. If TIMEOUT != 0 and wdog reaches TIMEOUT-1 while still stalled: rslt_q <= 0, err_q <= 1, go DONE.
//   - DONE: rsp_valid_o = 1, rsp_rslt_o = rslt_q, rsp_err_o = err_q.
//     - On rsp_ready_i & !stall_i: go IDLE.
//     - Back-to-back acceptance from DONE is not allowed; the next request is accepted no earlier than the cycle after IDLE is re-entered.
//  Latency with a zero-wait CFU:
//   - Accept at cycle 0; cfu_valid_o=1 in cycle 1; rsp_valid_o=1 in cycle 2.
//   - Each CFU stall cycle adds 1.
//  stall_i=1:
//   - No state, register or counter updates, except busy_cnt, which still counts.
//   - cfu_valid_o and operands hold; req_ready_o=0.
//   - A CFU completion in that cycle is not consumed; it is re-sampled next cycle. The CFU must hold its result while its stall_i is high.
//  busy_cnt_o: +1 each cycle state != IDLE; saturates at all-ones; never wraps.
//  Reset (any state, mid-op included): next edge gives
//   - state = IDLE, cfu_valid_o = 0, rsp_valid_o = 0, rsp_err_o = 0
//   - rsp_rslt_o = 0, op regs = 0, wdog = 0, busy_cnt_o = 0
//   - req_ready_o = 1 (unless stall_i). An in-flight op is dropped; no response is produced.
//  Outputs cfu_*_o, rsp_*_o: registered or decoded from state only. No combinational path req_* -> cfu_*.
//  req_ready_o: depends only on state and stall_i.
// STRUCTURE
//  FSM state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) go in shared include cfu_if.vh, next to the existing CFU macros; XLEN and CFU_CTRL_WIDTH come from config.vh.
//  One sub-module: cfu_watchdog (clear, enable, expire; counter width $clog2(TIMEOUT+1)). Everything else stays inline.
// TESTING
//  1 zero-wait: req ctrl=1, src1=5, src2=7 accepted at c0; CFU stall=0, rslt=0x1 -> cfu_valid c1 only; rsp_valid c2, rslt=0x1, err=0.
//  2 multi-cycle: CFU holds stall 3 cycles then rslt=0xDEADBEEF -> cfu ctrl/src stable 4 cycles; rsp_valid c5 with 0xDEADBEEF; busy_cnt=5 at c6.
//  3 backpressure: rsp_ready_i=0 for 4 cycles -> rsp_valid/rslt held; req_ready=0; new req accepted 1 cycle after handshake.
//  4 timeout: TIMEOUT=4, CFU stall stuck 1 -> abort after 4 WAIT cycles; rsp rslt=0, err=1; cfu_valid drops.
//  5 stall_i: assert 2 cycles in WAIT with cfu_stall_i=0 -> cfu_stall_o=1, no capture; capture the cycle after release.
//  6 reset mid-WAIT -> next cycle cfu_valid=0, rsp_valid=0, busy_cnt=0, req_ready=1; a following op completes normally.

Source files
------------

// File: rtl/cfu_issue_pkg.sv
// ---------------------------------------------------------------------------
// cfu_issue_pkg
//   Shared definitions for the CFU issue block: datapath widths of the CFU
//   port and the issue FSM state encoding.
//   Contents:
//     XLEN            register / operand / result width
//     CFU_CTRL_WIDTH  width of the funct (ctrl) field sent to the CFU
//     state_e         issue FSM states (IDLE=0, WAIT=1, DONE=2)
// ---------------------------------------------------------------------------
package cfu_issue_pkg;

   localparam int XLEN           = 32;
   localparam int CFU_CTRL_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cfu_issue_watchdog.sv
// ---------------------------------------------------------------------------
// cfu_watchdog
//   Counts consecutive CFU-stall cycles of one operation and flags expiry
//   when the count has reached TIMEOUT-1 and the CFU is still stalled.
//   TIMEOUT = 0 disables the watchdog (expire_o never asserts).
//   Ports:
//     clk_i     clock
//     rst_i     synchronous reset, active-high
//     clear_i   restart counting (new operation accepted)
//     enable_i  this cycle is a stalled WAIT cycle that may advance state
//     expire_o  abort the operation this cycle (combinational)
// ---------------------------------------------------------------------------
module cfu_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   // Keep at least one bit so a disabled watchdog still elaborates cleanly.
   localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int            LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST   = CW'(LAST_I);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d    = cnt_q;
      expire_o = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (TIMEOUT != 0)) begin
         // Counter stops at LAST: the op leaves WAIT in the expiring cycle.
         if (cnt_q == LAST) begin
            expire_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cfu_issue.sv
// ---------------------------------------------------------------------------
// cfu_issue
//   CPU-side initiator for the CFU port. Takes one custom-instruction request
//   from execute, registers its operands, issues them to the CFU, holds them
//   while the CFU stalls, captures the result and hands it to writeback.
//   A watchdog aborts a CFU that stalls too long (response err=1, rslt=0).
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     stall_i                      global pipeline stall, freezes the block
//     req_valid_i/req_ready_o      request handshake from execute
//     req_ctrl_i, req_src1/2_i     op funct bits and operands
//     rsp_valid_o/rsp_ready_i      response handshake to writeback
//     rsp_rslt_o, rsp_err_o        result and watchdog-abort flag
//     cfu_valid_o, cfu_ctrl_o,
//     cfu_src1_o, cfu_src2_o       request side of the CFU port
//     cfu_stall_o                  copy of stall_i for the CFU
//     cfu_stall_i, cfu_rslt_i      CFU not-ready flag and result
//     busy_cnt_o                   saturating count of non-IDLE cycles
// ---------------------------------------------------------------------------
module cfu_issue
   import cfu_issue_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int CNT_W   = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      stall_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [CFU_CTRL_WIDTH-1:0] req_ctrl_i,
   input  logic [XLEN-1:0]           req_src1_i,
   input  logic [XLEN-1:0]           req_src2_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [XLEN-1:0]           rsp_rslt_o,
   output logic                      rsp_err_o,
   output logic                      cfu_valid_o,
   output logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_o,
   output logic [XLEN-1:0]           cfu_src1_o,
   output logic [XLEN-1:0]           cfu_src2_o,
   output logic                      cfu_stall_o,
   input  logic                      cfu_stall_i,
   input  logic [XLEN-1:0]           cfu_rslt_i,
   output logic [CNT_W-1:0]          busy_cnt_o
);

   state_e                      state_q, state_d;
   logic [CFU_CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
   logic [XLEN-1:0]             src1_q, src1_d;
   logic [XLEN-1:0]             src2_q, src2_d;
   logic [XLEN-1:0]             rslt_q, rslt_d;
   logic                        err_q, err_d;
   logic [CNT_W-1:0]            busy_q, busy_d;

   logic accept;
   logic wd_enable;
   logic wd_expire;

   // Ready is a function of state and stall_i only, so execute never sees
   // a path from its own valid back into ready.
   assign req_ready_o = (state_q == ST_IDLE) && !stall_i;
   assign accept      = req_valid_i && req_ready_o;

   // Only stalled WAIT cycles that are not frozen by stall_i count.
   assign wd_enable   = (state_q == ST_WAIT) && cfu_stall_i && !stall_i;

   cfu_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (accept),
      .enable_i (wd_enable),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      rslt_d  = rslt_q;
      err_d   = err_q;
      busy_d  = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               ctrl_d  = req_ctrl_i;
               src1_d  = req_src1_i;
               src2_d  = req_src2_i;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // While frozen, a CFU completion is left for the next cycle.
            if (!stall_i) begin
               if (!cfu_stall_i) begin
                  rslt_d  = cfu_rslt_i;
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end else if (wd_expire) begin
                  rslt_d  = '0;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Always pass through IDLE so a new op starts a cycle later.
            if (rsp_ready_i && !stall_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Benchmark counter keeps running through stall_i.
      if ((state_q != ST_IDLE) && (busy_q != '1)) begin
         busy_d = busy_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         rslt_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         rslt_q  <= rslt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign cfu_valid_o = (state_q == ST_WAIT);
   assign cfu_ctrl_o  = ctrl_q;
   assign cfu_src1_o  = src1_q;
   assign cfu_src2_o  = src2_q;
   assign cfu_stall_o = stall_i;

   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_rslt_o  = rslt_q;
   assign rsp_err_o   = err_q;

   assign busy_cnt_o  = busy_q;

endmodule

// File: tb/tb_cfu_issue.sv
// ---------------------------------------------------------------------------
// tb_cfu_issue
//   Self-checking bench for cfu_issue (TIMEOUT=4). A small CFU model answers
//   after a programmable number of stall cycles (or never). Expected
//   responses are queued when a request is driven and compared when the
//   response handshake happens.
// ---------------------------------------------------------------------------
module tb_cfu_issue;
   import cfu_issue_pkg::*;

   localparam int TB_TIMEOUT = 4;
   localparam int TB_CNT_W   = 32;

   logic                      clk        = 1'b0;
   logic                      rst        = 1'b1;
   logic                      stall      = 1'b0;
   logic                      req_valid  = 1'b0;
   logic                      rsp_ready  = 1'b0;
   logic [CFU_CTRL_WIDTH-1:0] req_ctrl   = '0;
   logic [XLEN-1:0]           req_src1   = '0;
   logic [XLEN-1:0]           req_src2   = '0;
   logic                      cfu_stall_in;
   logic [XLEN-1:0]           cfu_rslt_in;

   logic                      req_ready_o;
   logic                      rsp_valid_o;
   logic [XLEN-1:0]           rsp_rslt_o;
   logic                      rsp_err_o;
   logic                      cfu_valid_o;
   logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_o;
   logic [XLEN-1:0]           cfu_src1_o;
   logic [XLEN-1:0]           cfu_src2_o;
   logic                      cfu_stall_o;
   logic [TB_CNT_W-1:0]       busy_cnt_o;

   int checks       = 0;
   int failures     = 0;
   int rsp_seen     = 0;
   int rsp_expected = 0;

   // CFU model: cfu_lat < 0 means the CFU never finishes.
   int              cfu_lat  = 0;
   int              cfu_seen = 0;
   logic [XLEN-1:0] cfu_res  = '0;

   typedef struct packed {
      logic [XLEN-1:0] rslt;
      logic            err;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;

   always #5 clk = ~clk;

   cfu_issue #(
      .TIMEOUT (TB_TIMEOUT),
      .CNT_W   (TB_CNT_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .stall_i     (stall),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_ctrl_i  (req_ctrl),
      .req_src1_i  (req_src1),
      .req_src2_i  (req_src2),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_rslt_o  (rsp_rslt_o),
      .rsp_err_o   (rsp_err_o),
      .cfu_valid_o (cfu_valid_o),
      .cfu_ctrl_o  (cfu_ctrl_o),
      .cfu_src1_o  (cfu_src1_o),
      .cfu_src2_o  (cfu_src2_o),
      .cfu_stall_o (cfu_stall_o),
      .cfu_stall_i (cfu_stall_in),
      .cfu_rslt_i  (cfu_rslt_in),
      .busy_cnt_o  (busy_cnt_o)
   );

   // A garbage value while stalled exposes a capture in the wrong cycle.
   always_comb begin
      cfu_stall_in = 1'b0;
      cfu_rslt_in  = cfu_res;
      if (cfu_valid_o && ((cfu_lat < 0) || (cfu_seen < cfu_lat))) begin
         cfu_stall_in = 1'b1;
         cfu_rslt_in  = 32'hBAD0_BAD0;
      end
   end

   always @(posedge clk) begin
      if (rst || !cfu_valid_o) cfu_seen <= 0;
      else if (!stall)         cfu_seen <= cfu_seen + 1;
   end

   // Scoreboard consumer: samples just after the inputs for the next edge settle.
   always begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid_o && rsp_ready && !stall) begin
         rsp_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got rslt=%h err=%b required no response", rsp_rslt_o, rsp_err_o);
         end else begin
            exp_e = exp_q.pop_front();
            if ({rsp_rslt_o, rsp_err_o} !== {exp_e.rslt, exp_e.err}) begin
               failures++;
               $display("FAIL sb_rsp got rslt=%h err=%b required rslt=%h err=%b",
                        rsp_rslt_o, rsp_err_o, exp_e.rslt, exp_e.err);
            end else begin
               $display("rsp rslt=%h err=%b ok", rsp_rslt_o, rsp_err_o);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      stall     = 1'b0;
      tick;
      rst = 1'b0;
      rsp_expected -= exp_q.size();
      exp_q.delete();
   endtask

   // Presents a request and returns at the negedge of the first WAIT cycle.
   task automatic issue(input int c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] er, input logic ee);
      exp_t e;
      int   n;
      req_ctrl  = CFU_CTRL_WIDTH'(c);
      req_src1  = a;
      req_src2  = b;
      req_valid = 1'b1;
      e.rslt    = er;
      e.err     = ee;
      exp_q.push_back(e);
      rsp_expected++;
      $display("req ctrl=%0d src1=%h src2=%h", c, a, b);
      #1;
      n = 0;
      while (!req_ready_o && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL issue_accept got ready=%b required 1 within 20 cycles", req_ready_o);
      end
      tick;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp;
      int n;
      n = 0;
      while (!rsp_valid_o && n < 50) begin
         tick;
         n++;
      end
      checks++;
      if (rsp_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL wait_rsp got rsp_valid=%b required 1 within 50 cycles", rsp_valid_o);
      end
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if ({cfu_valid_o, rsp_valid_o, rsp_err_o, req_ready_o} !== 4'b0001) begin
         failures++;
         $display("FAIL reset_flags got cfu_v/rsp_v/err/ready=%b required 0001",
                  {cfu_valid_o, rsp_valid_o, rsp_err_o, req_ready_o});
      end
      checks++;
      if ({rsp_rslt_o, busy_cnt_o} !== {XLEN'(0), TB_CNT_W'(0)}) begin
         failures++;
         $display("FAIL reset_rslt_busy got rslt=%h busy=%0d required 0 0", rsp_rslt_o, busy_cnt_o);
      end
      checks++;
      if ({cfu_ctrl_o, cfu_src1_o, cfu_src2_o} !== '0) begin
         failures++;
         $display("FAIL reset_opregs got ctrl=%h src1=%h src2=%h required 0", cfu_ctrl_o, cfu_src1_o, cfu_src2_o);
      end
      stall = 1'b1;
      #1;
      checks++;
      if ({req_ready_o, cfu_stall_o} !== 2'b01) begin
         failures++;
         $display("FAIL reset_stall_ready got ready/cfu_stall=%b required 01", {req_ready_o, cfu_stall_o});
      end
      stall = 1'b0;
      tick;
      $display("test_reset done");
   endtask

   task automatic test_zero_wait;
      do_reset;
      cfu_lat   = 0;
      cfu_res   = 32'h1;
      rsp_ready = 1'b1;
      issue(1, 32'd5, 32'd7, 32'h1, 1'b0);
      checks++;
      if ({cfu_valid_o, rsp_valid_o, req_ready_o} !== 3'b100) begin
         failures++;
         $display("FAIL zw_c1 got cfu_v/rsp_v/ready=%b required 100", {cfu_valid_o, rsp_valid_o, req_ready_o});
      end
      checks++;
      if ({cfu_ctrl_o, cfu_src1_o, cfu_src2_o} !== {CFU_CTRL_WIDTH'(1), 32'd5, 32'd7}) begin
         failures++;
         $display("FAIL zw_ops got ctrl=%0d src1=%0d src2=%0d required 1 5 7", cfu_ctrl_o, cfu_src1_o, cfu_src2_o);
      end
      tick;
      checks++;
      if ({cfu_valid_o, rsp_valid_o, rsp_err_o, rsp_rslt_o} !== {3'b010, 32'h1}) begin
         failures++;
         $display("FAIL zw_c2 got cfu_v=%b rsp_v=%b err=%b rslt=%h required 0 1 0 00000001",
                  cfu_valid_o, rsp_valid_o, rsp_err_o, rsp_rslt_o);
      end
      tick;
      checks++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
         failures++;
         $display("FAIL zw_c3 got rsp_v/ready=%b required 01", {rsp_valid_o, req_ready_o});
      end
      $display("test_zero_wait done");
   endtask

   task automatic test_multi_cycle;
      do_reset;
      cfu_lat   = 3;
      cfu_res   = 32'hDEAD_BEEF;
      rsp_ready = 1'b1;
      issue(3, 32'h11, 32'h22, 32'hDEAD_BEEF, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({cfu_valid_o, rsp_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o} !==
             {2'b10, CFU_CTRL_WIDTH'(3), 32'h11, 32'h22}) begin
            failures++;
            $display("FAIL mc_hold_c%0d got cfu_v=%b rsp_v=%b ctrl=%0d src1=%h src2=%h required 1 0 3 11 22",
                     k, cfu_valid_o, rsp_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o);
         end
         tick;
      end
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_rslt_o} !== {2'b10, 32'hDEAD_BEEF}) begin
         failures++;
         $display("FAIL mc_c5 got rsp_v=%b err=%b rslt=%h required 1 0 deadbeef", rsp_valid_o, rsp_err_o, rsp_rslt_o);
      end
      tick;
      checks++;
      if (busy_cnt_o !== TB_CNT_W'(5)) begin
         failures++;
         $display("FAIL mc_busy_c6 got %0d required 5", busy_cnt_o);
      end
      tick;
      checks++;
      if (busy_cnt_o !== TB_CNT_W'(5)) begin
         failures++;
         $display("FAIL mc_busy_idle got %0d required 5", busy_cnt_o);
      end
      $display("test_multi_cycle done");
   endtask

   task automatic test_backpressure;
      do_reset;
      cfu_lat   = 0;
      cfu_res   = 32'h1234;
      rsp_ready = 1'b0;
      issue(2, 32'h9, 32'hA, 32'h1234, 1'b0);
      tick;
      // Second request waits while the first response is held.
      cfu_res   = 32'h4444;
      req_ctrl  = CFU_CTRL_WIDTH'(4);
      req_src1  = 32'h40;
      req_src2  = 32'h41;
      req_valid = 1'b1;
      exp_q.push_back(exp_t'{rslt: 32'h4444, err: 1'b0});
      rsp_expected++;
      $display("req ctrl=4 src1=00000040 src2=00000041 (held)");
      for (int k = 2; k <= 5; k++) begin
         checks++;
         if ({rsp_valid_o, req_ready_o, rsp_rslt_o} !== {2'b10, 32'h1234}) begin
            failures++;
            $display("FAIL bp_hold_c%0d got rsp_v=%b ready=%b rslt=%h required 1 0 00001234",
                     k, rsp_valid_o, req_ready_o, rsp_rslt_o);
         end
         tick;
      end
      rsp_ready = 1'b1;
      checks++;
      if ({rsp_valid_o, req_ready_o} !== 2'b10) begin
         failures++;
         $display("FAIL bp_c6 got rsp_v/ready=%b required 10", {rsp_valid_o, req_ready_o});
      end
      tick;
      checks++;
      if ({rsp_valid_o, cfu_valid_o, req_ready_o} !== 3'b001) begin
         failures++;
         $display("FAIL bp_c7_idle got rsp_v/cfu_v/ready=%b required 001", {rsp_valid_o, cfu_valid_o, req_ready_o});
      end
      tick;
      req_valid = 1'b0;
      checks++;
      if ({cfu_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o} !== {1'b1, CFU_CTRL_WIDTH'(4), 32'h40, 32'h41}) begin
         failures++;
         $display("FAIL bp_c8_issue got cfu_v=%b ctrl=%0d src1=%h src2=%h required 1 4 40 41",
                  cfu_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o);
      end
      wait_rsp;
      tick;
      $display("test_backpressure done");
   endtask

   task automatic test_timeout;
      do_reset;
      cfu_lat   = -1;
      rsp_ready = 1'b1;
      issue(5, 32'h1, 32'h2, 32'h0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({cfu_valid_o, rsp_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL to_wait_c%0d got cfu_v/rsp_v=%b required 10", k, {cfu_valid_o, rsp_valid_o});
         end
         tick;
      end
      checks++;
      if ({cfu_valid_o, rsp_valid_o, rsp_err_o, rsp_rslt_o} !== {3'b011, 32'h0}) begin
         failures++;
         $display("FAIL to_abort got cfu_v=%b rsp_v=%b err=%b rslt=%h required 0 1 1 00000000",
                  cfu_valid_o, rsp_valid_o, rsp_err_o, rsp_rslt_o);
      end
      tick;
      checks++;
      if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
         failures++;
         $display("FAIL to_idle got rsp_v/ready=%b required 01", {rsp_valid_o, req_ready_o});
      end
      $display("test_timeout done");
   endtask

   task automatic test_stall;
      do_reset;
      cfu_lat   = 0;
      cfu_res   = 32'h55AA;
      rsp_ready = 1'b1;
      issue(6, 32'h3, 32'h4, 32'h55AA, 1'b0);
      stall = 1'b1;
      #1;
      checks++;
      if ({cfu_stall_o, req_ready_o, cfu_valid_o} !== 3'b101) begin
         failures++;
         $display("FAIL st_c1 got cfu_stall/ready/cfu_v=%b required 101", {cfu_stall_o, req_ready_o, cfu_valid_o});
      end
      tick;
      checks++;
      if ({cfu_valid_o, rsp_valid_o, cfu_src1_o} !== {2'b10, 32'h3}) begin
         failures++;
         $display("FAIL st_c2 got cfu_v=%b rsp_v=%b src1=%h required 1 0 3", cfu_valid_o, rsp_valid_o, cfu_src1_o);
      end
      tick;
      checks++;
      if ({cfu_valid_o, rsp_valid_o} !== 2'b10) begin
         failures++;
         $display("FAIL st_c3 got cfu_v/rsp_v=%b required 10", {cfu_valid_o, rsp_valid_o});
      end
      stall = 1'b0;
      #1;
      checks++;
      if (cfu_stall_o !== 1'b0) begin
         failures++;
         $display("FAIL st_release got cfu_stall=%b required 0", cfu_stall_o);
      end
      tick;
      checks++;
      if ({rsp_valid_o, rsp_rslt_o, busy_cnt_o} !== {1'b1, 32'h55AA, TB_CNT_W'(3)}) begin
         failures++;
         $display("FAIL st_c4 got rsp_v=%b rslt=%h busy=%0d required 1 000055aa 3", rsp_valid_o, rsp_rslt_o, busy_cnt_o);
      end
      stall = 1'b1;
      tick;
      checks++;
      if ({rsp_valid_o, busy_cnt_o} !== {1'b1, TB_CNT_W'(4)}) begin
         failures++;
         $display("FAIL st_done_hold got rsp_v=%b busy=%0d required 1 4", rsp_valid_o, busy_cnt_o);
      end
      stall = 1'b0;
      tick;
      checks++;
      if (rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL st_c6 got rsp_v=%b required 0", rsp_valid_o);
      end
      $display("test_stall done");
   endtask

   task automatic test_reset_mid;
      do_reset;
      cfu_lat   = -1;
      rsp_ready = 1'b1;
      issue(7, 32'h8, 32'h9, 32'h0, 1'b1);
      tick;
      do_reset;
      rsp_ready = 1'b1;
      checks++;
      if ({cfu_valid_o, rsp_valid_o, rsp_err_o, req_ready_o, busy_cnt_o} !== {4'b0001, TB_CNT_W'(0)}) begin
         failures++;
         $display("FAIL rm_after got cfu_v=%b rsp_v=%b err=%b ready=%b busy=%0d required 0 0 0 1 0",
                  cfu_valid_o, rsp_valid_o, rsp_err_o, req_ready_o, busy_cnt_o);
      end
      cfu_lat = 1;
      cfu_res = 32'h0F0F;
      issue(8, 32'h1, 32'h1, 32'h0F0F, 1'b0);
      wait_rsp;
      tick;
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset;
      test_zero_wait;
      test_multi_cycle;
      test_backpressure;
      test_timeout;
      test_stall;
      test_reset_mid;
      tick;
      checks++;
      if ((exp_q.size() != 0) || (rsp_seen != rsp_expected)) begin
         failures++;
         $display("FAIL sb_final got responses=%0d pending=%0d required responses=%0d pending=0",
                  rsp_seen, exp_q.size(), rsp_expected);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
